// File: rtl/execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the EX stage of the 16-bit pipelined CPU:
//   - datapath / immediate widths
//   - 4-bit opcode encodings (control[3:0])
//   - sign_extend(): immediate field -> DATA_W two's complement value
// ---------------------------------------------------------------------------
package execute_stage_pkg;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 7;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_ADDI   = 4'd3;
    localparam logic [3:0] OP_SHLLI  = 4'd4;
    localparam logic [3:0] OP_SHRLI  = 4'd5;
    localparam logic [3:0] OP_JUMP   = 4'd6;
    localparam logic [3:0] OP_JUMPL  = 4'd7;
    localparam logic [3:0] OP_JUMPG  = 4'd8;
    localparam logic [3:0] OP_JUMPE  = 4'd9;
    localparam logic [3:0] OP_JUMPNE = 4'd10;
    localparam logic [3:0] OP_CMP    = 4'd11;
    localparam logic [3:0] OP_LOAD   = 4'd12;
    localparam logic [3:0] OP_LOADI  = 4'd13;
    localparam logic [3:0] OP_STORE  = 4'd14;
    localparam logic [3:0] OP_MOV    = 4'd15;

    function automatic logic [DATA_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/execute_alu.sv
// ---------------------------------------------------------------------------
// execute_alu
// Purely combinational ALU of the EX stage.
// Ports:
//   op_i      : 4-bit opcode
//   a_i, b_i  : source operands (reg1, reg2)
//   simm_i    : sign-extended immediate
//   shamt_i   : shift amount (immediate[3:0])
//   result_o  : ALU result / memory address
//   wr_en_o   : opcode writes the register file
//   eq_o/gt_o/lt_o : unsigned compare of a_i against b_i
// ---------------------------------------------------------------------------
module execute_alu
    import execute_stage_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] simm_i,
    input  logic [3:0]        shamt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              wr_en_o,
    output logic              eq_o,
    output logic              gt_o,
    output logic              lt_o
);

    always_comb begin
        result_o = '0;
        wr_en_o  = 1'b0;
        unique case (op_i)
            OP_SUB:   begin result_o = a_i - b_i;        wr_en_o = 1'b1; end
            OP_ADD:   begin result_o = a_i + b_i;        wr_en_o = 1'b1; end
            OP_ADDI:  begin result_o = a_i + simm_i;     wr_en_o = 1'b1; end
            OP_SHLLI: begin result_o = a_i << shamt_i;   wr_en_o = 1'b1; end
            OP_SHRLI: begin result_o = a_i >> shamt_i;   wr_en_o = 1'b1; end
            OP_LOAD:  begin result_o = a_i + simm_i;     wr_en_o = 1'b1; end
            OP_LOADI: begin result_o = simm_i;           wr_en_o = 1'b1; end
            // Store address only; nothing written back.
            OP_STORE: begin result_o = a_i + simm_i;     wr_en_o = 1'b0; end
            OP_MOV:   begin result_o = a_i;              wr_en_o = 1'b1; end
            // NOP, jumps and CMP produce a zero result and no write-back.
            default:  begin result_o = '0;               wr_en_o = 1'b0; end
        endcase
    end

    // Unsigned compare; exactly one of these is true for any operand pair.
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// EX stage of the 16-bit five-stage CPU. Every output is a flop updated on
// the rising clock edge (1-cycle latency, one instruction per cycle, no
// stall or handshake). Synchronous active-high reset clears all outputs.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   control_in[4:0]     : opcode (bits[3:0] used, bit 4 passed through only)
//   dest_index_in[4:0]  : destination register index
//   reg1_data, reg2_data: source operands (reg2 is also store data)
//   npc                 : address of the following instruction
//   immediate[6:0]      : two's complement immediate
//   dest_index_out, control_out : registered copies of the inputs
//   output_reg          : registered reg2_data (store data)
//   result_out          : registered ALU result / memory address
//   target              : registered next-PC selection
//   DEST_REG_WRITE_EN   : registered register-file write enable
//   ZF, GF, LF          : compare flags, written only by CMP
// ---------------------------------------------------------------------------
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  control_in,
    input  logic [4:0]  dest_index_in,
    input  logic [15:0] reg1_data,
    input  logic [15:0] reg2_data,
    input  logic [15:0] npc,
    input  logic [6:0]  immediate,
    output logic [4:0]  dest_index_out,
    output logic [4:0]  control_out,
    output logic [15:0] output_reg,
    output logic [15:0] result_out,
    output logic [15:0] target,
    output logic        DEST_REG_WRITE_EN,
    output logic        ZF,
    output logic        GF,
    output logic        LF
);

    logic [3:0]        op;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_wr_en;
    logic              cmp_eq, cmp_gt, cmp_lt;
    logic              taken;

    logic [4:0]        dest_q, dest_d;
    logic [4:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              wr_en_q, wr_en_d;
    logic              zf_q, zf_d, gf_q, gf_d, lf_q, lf_d;

    assign op   = control_in[3:0];
    assign simm = sign_extend(immediate);

    execute_alu u_alu (
        .op_i     (op),
        .a_i      (reg1_data),
        .b_i      (reg2_data),
        .simm_i   (simm),
        .shamt_i  (immediate[3:0]),
        .result_o (alu_result),
        .wr_en_o  (alu_wr_en),
        .eq_o     (cmp_eq),
        .gt_o     (cmp_gt),
        .lt_o     (cmp_lt)
    );

    // Branch conditions look at the flag registers, so a CMP on the previous
    // edge is already visible to a conditional jump in the next cycle.
    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_JUMP:   taken = 1'b1;
            OP_JUMPL:  taken = lf_q;
            OP_JUMPG:  taken = gf_q;
            OP_JUMPE:  taken = zf_q;
            OP_JUMPNE: taken = ~zf_q;
            default:   taken = 1'b0;
        endcase
    end

    always_comb begin
        dest_d   = dest_index_in;
        ctrl_d   = control_in;
        store_d  = reg2_data;
        result_d = alu_result;
        wr_en_d  = alu_wr_en;
        target_d = taken ? (npc + simm) : npc;
        zf_d     = zf_q;
        gf_d     = gf_q;
        lf_d     = lf_q;
        if (op == OP_CMP) begin
            zf_d = cmp_eq;
            gf_d = cmp_gt;
            lf_d = cmp_lt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q   <= '0;
            ctrl_q   <= '0;
            store_q  <= '0;
            result_q <= '0;
            target_q <= '0;
            wr_en_q  <= 1'b0;
            zf_q     <= 1'b0;
            gf_q     <= 1'b0;
            lf_q     <= 1'b0;
        end else begin
            dest_q   <= dest_d;
            ctrl_q   <= ctrl_d;
            store_q  <= store_d;
            result_q <= result_d;
            target_q <= target_d;
            wr_en_q  <= wr_en_d;
            zf_q     <= zf_d;
            gf_q     <= gf_d;
            lf_q     <= lf_d;
        end
    end

    assign dest_index_out    = dest_q;
    assign control_out       = ctrl_q;
    assign output_reg        = store_q;
    assign result_out        = result_q;
    assign target            = target_q;
    assign DEST_REG_WRITE_EN = wr_en_q;
    assign ZF                = zf_q;
    assign GF                = gf_q;
    assign LF                = lf_q;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Directed bench for execute_stage: each step drives one instruction, waits
// one rising edge, then compares the registered outputs 1 time unit later
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic [4:0]  control_in;
    logic [4:0]  dest_index_in;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [15:0] npc;
    logic [6:0]  immediate;
    logic [4:0]  dest_index_out;
    logic [4:0]  control_out;
    logic [15:0] output_reg;
    logic [15:0] result_out;
    logic [15:0] target;
    logic        DEST_REG_WRITE_EN;
    logic        ZF, GF, LF;

    int tests_run;
    int tests_failed;

    execute_stage dut (
        .clk               (clk),
        .reset             (reset),
        .control_in        (control_in),
        .dest_index_in     (dest_index_in),
        .reg1_data         (reg1_data),
        .reg2_data         (reg2_data),
        .npc               (npc),
        .immediate         (immediate),
        .dest_index_out    (dest_index_out),
        .control_out       (control_out),
        .output_reg        (output_reg),
        .result_out        (result_out),
        .target            (target),
        .DEST_REG_WRITE_EN (DEST_REG_WRITE_EN),
        .ZF                (ZF),
        .GF                (GF),
        .LF                (LF)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, observed, expected);
        end
    endtask

    // Apply one instruction and move past the capturing edge.
    task automatic drive(input logic [4:0] ctl, input logic [4:0] dst, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] pc, input logic [6:0] imm);
        control_in    = ctl;
        dest_index_in = dst;
        reg1_data     = r1;
        reg2_data     = r2;
        npc           = pc;
        immediate     = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic g, input logic l);
        check(tag, {13'd0, ZF, GF, LF}, {13'd0, z, g, l});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;

        // Reset with busy inputs (MOV would otherwise write 0x1234 etc.)
        drive(5'd15, 5'd9, 16'h1234, 16'hABCD, 16'h0040, 7'h05);
        drive(5'd11, 5'd9, 16'h0009, 16'h0001, 16'h0040, 7'h05);
        check("rst_result",  result_out, 16'h0000);
        check("rst_target",  target, 16'h0000);
        check("rst_outreg",  output_reg, 16'h0000);
        check("rst_ctrl",    {11'd0, control_out}, 16'h0000);
        check("rst_dest",    {11'd0, dest_index_out}, 16'h0000);
        check("rst_wen",     {15'd0, DEST_REG_WRITE_EN}, 16'h0000);
        check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Arithmetic
        drive(5'd1, 5'd2, 16'd10, 16'd3, 16'h0002, 7'h00);
        check("sub_res",  result_out, 16'd7);
        check("sub_wen",  {15'd0, DEST_REG_WRITE_EN}, 16'd1);
        check("sub_dest", {11'd0, dest_index_out}, 16'd2);
        check("sub_tgt",  target, 16'h0002);
        drive(5'd2, 5'd3, 16'd10, 16'd5, 16'h0003, 7'h00);
        check("add_res",  result_out, 16'd15);
        drive(5'd1, 5'd4, 16'd3, 16'd10, 16'h0004, 7'h00);
        check("sub_neg",  result_out, 16'hFFF9);
        drive(5'h12, 5'd5, 16'd10, 16'd5, 16'h0005, 7'h00);
        check("add_b4_res",  result_out, 16'd15);
        check("add_b4_ctrl", {11'd0, control_out}, 16'h0012);
        drive(5'd3, 5'd6, 16'd10, 16'd0, 16'h0006, 7'h07);
        check("addi_pos", result_out, 16'd17);
        drive(5'd3, 5'd6, 16'd10, 16'd0, 16'h0006, 7'h7F);
        check("addi_neg", result_out, 16'd9);
        drive(5'd4, 5'd7, 16'd8, 16'd0, 16'h0007, 7'h01);
        check("shlli",    result_out, 16'd16);
        drive(5'd5, 5'd7, 16'd8, 16'd0, 16'h0007, 7'h01);
        check("shrli",    result_out, 16'd4);
        drive(5'd5, 5'd7, 16'h8000, 16'd0, 16'h0007, 7'h0F);
        check("shrli_15", result_out, 16'd1);
        check_flags("flags_idle", 1'b0, 1'b0, 1'b0);

        // Compare / conditional jumps on GF
        drive(5'd11, 5'd0, 16'd8, 16'd0, 16'h0008, 7'h00);
        check_flags("cmp_gt", 1'b0, 1'b1, 1'b0);
        check("cmp_res", result_out, 16'd0);
        check("cmp_wen", {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        drive(5'd0, 5'd0, 16'd1, 16'd9, 16'h0009, 7'h00);
        check_flags("nop_hold", 1'b0, 1'b1, 1'b0);
        drive(5'd8, 5'd0, 16'd0, 16'd0, 16'h0020, 7'h01);
        check("jumpg_t",  target, 16'h0021);
        check("jumpg_res", result_out, 16'd0);
        drive(5'd7, 5'd0, 16'd0, 16'd0, 16'h0020, 7'h01);
        check("jumpl_nt", target, 16'h0020);
        drive(5'd9, 5'd0, 16'd0, 16'd0, 16'h0020, 7'h01);
        check("jumpe_nt", target, 16'h0020);
        check_flags("jump_hold", 1'b0, 1'b1, 1'b0);

        // Equal compare, then back-to-back conditional jump
        drive(5'd11, 5'd0, 16'd5, 16'd5, 16'h000A, 7'h00);
        check_flags("cmp_eq", 1'b1, 1'b0, 1'b0);
        drive(5'd9, 5'd0, 16'd0, 16'd0, 16'h0010, 7'h7E);
        check("jumpe_t",  target, 16'h000E);
        drive(5'd10, 5'd0, 16'd0, 16'd0, 16'h0010, 7'h7E);
        check("jumpne_nt", target, 16'h0010);
        drive(5'd6, 5'd0, 16'd0, 16'd0, 16'h0010, 7'h7E);
        check("jump_t",   target, 16'h000E);

        // Less-than compare immediately followed by JUMPL / JUMPNE
        drive(5'd11, 5'd0, 16'd2, 16'hF000, 16'h000B, 7'h00);
        check_flags("cmp_lt", 1'b0, 1'b0, 1'b1);
        drive(5'd7, 5'd0, 16'd0, 16'd0, 16'h0100, 7'h03);
        check("jumpl_t",  target, 16'h0103);
        drive(5'd10, 5'd0, 16'd0, 16'd0, 16'h0100, 7'h40);
        check("jumpne_t", target, 16'h00C0);

        // Memory ops / MOV
        drive(5'd14, 5'd1, 16'h0100, 16'hBEEF, 16'h0030, 7'h04);
        check("store_addr", result_out, 16'h0104);
        check("store_data", output_reg, 16'hBEEF);
        check("store_wen",  {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        check("store_tgt",  target, 16'h0030);
        drive(5'd12, 5'd3, 16'h0100, 16'h0000, 16'h0031, 7'h7C);
        check("load_addr",  result_out, 16'h00FC);
        check("load_wen",   {15'd0, DEST_REG_WRITE_EN}, 16'd1);
        drive(5'd13, 5'd8, 16'h5555, 16'h0000, 16'h0032, 7'h40);
        check("loadi",      result_out, 16'hFFC0);
        check("loadi_wen",  {15'd0, DEST_REG_WRITE_EN}, 16'd1);
        drive(5'd15, 5'd31, 16'h1234, 16'h7777, 16'h0033, 7'h00);
        check("mov",        result_out, 16'h1234);
        check("mov_dest",   {11'd0, dest_index_out}, 16'd31);
        check("mov_outreg", output_reg, 16'h7777);

        // Reset mid-stream clears flags and outputs again
        reset = 1'b1;
        drive(5'd15, 5'd31, 16'h1234, 16'h7777, 16'h0033, 7'h00);
        check("rst2_result", result_out, 16'h0000);
        check_flags("rst2_flags", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
